// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
// Parametrised serial message transmitter. A start request snapshots the
// payload, and the block then sends one message as LSB-first async frames:
//   header bytes (HDR, first byte in the top bits) -> payload bytes (MSB byte
//   first) -> optional LF, CR trailer.
// Each byte is sent as start bit, 8 data bits, an optional parity bit and
// STOP_BITS stop bits. Consecutive bytes can be separated by GAP_BITS idle bit
// periods.
//
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   start    message request, taken only while ready=1
//   data_in  payload; the first byte sent is data_in[8*DATA_BYTES-1 -: 8]
//   ready    idle and able to accept start (also high in the done cycle)
//   busy     message in progress (~ready)
//   done     one-cycle pulse at the end of a message
//   tx       serial line, idle high, driven straight from a flop
// -----------------------------------------------------------------------------
module uart_frame_tx #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BYTES = 7,
  parameter int HDR_BYTES  = 4,
  parameter logic [8*((HDR_BYTES > 0) ? HDR_BYTES : 1)-1:0] HDR = 32'h443D2020,
  parameter int TRAILER_EN = 1,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*DATA_BYTES-1:0] data_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic                    tx
);

  localparam int MSG_BYTES = HDR_BYTES + DATA_BYTES + ((TRAILER_EN != 0) ? 2 : 0);
  localparam int IDX_W     = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam int CNT_W     = $clog2(CLK_DIV);
  // One counter walks data bits, stop bits and gap periods in turn.
  localparam int BIT_W     = ($clog2(GAP_BITS + 1) > 3) ? $clog2(GAP_BITS + 1) : 3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tx_q, tx_d;
  logic [8*DATA_BYTES-1:0] shadow_q;
  logic [7:0]              byte_q;

  logic tick;
  logic accept;
  logic par_bit;

  // Byte i of the message: header, then payload, then LF, CR.
  function automatic logic [7:0] msg_byte(input int i, input logic [8*DATA_BYTES-1:0] pl);
    if (i < HDR_BYTES)
      return HDR[8*(HDR_BYTES-1-i) +: 8];
    else if (i < HDR_BYTES + DATA_BYTES)
      return pl[8*(DATA_BYTES-1-(i-HDR_BYTES)) +: 8];
    else if (i == HDR_BYTES + DATA_BYTES)
      return 8'h0A;
    else
      return 8'h0D;
  endfunction

  assign ready   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy    = ~ready;
  assign done    = (state_q == S_DONE);
  assign tx      = tx_q;
  assign accept  = ready && start;
  assign tick    = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign par_bit = (^byte_q) ^ (PARITY == 2);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: the payload snapshot and current byte carry no reset: each is always
  // written (on accept / in LOAD) before the control path reads it.
  always_ff @(posedge clk) begin
    if (accept)            shadow_q <= data_in;
    if (state_q == S_LOAD) byte_q   <= msg_byte(int'(idx_q), shadow_q);
  end

  // tx_d is the line level for the state being entered, so tx changes on the
  // same edge as the state and is never decoded combinationally.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    idx_d   = idx_q;
    tx_d    = tx_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
        if (start) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end

      // One cycle, line still high: counts as an extension of the stop level.
      S_LOAD: begin
        cnt_d   = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end

      S_START: begin
        if (tick) begin
          bit_d   = '0;
          tx_d    = byte_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (tick) begin
          if (bit_q == BIT_W'(7)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_bit;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = byte_q[bit_q[2:0] + 3'd1];
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (tick) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (idx_q == IDX_W'(MSG_BYTES - 1)) begin
              state_d = S_DONE;
            end else if (GAP_BITS > 0) begin
              state_d = S_GAP;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_LOAD;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      // Only entered between bytes, never after the last one.
      S_GAP: begin
        if (tick) begin
          if (bit_q == BIT_W'(GAP_BITS - 1)) begin
            bit_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
// Randomised self-checking bench for uart_frame_tx. A reference model expands
// each message into the expected per-cycle {tx, ready, busy, done} stream,
// working from the byte list, the frame format and the bit period. Every
// cycle of every message is compared, and so is the measured accept-to-done
// length against the closed-form message length.
// -----------------------------------------------------------------------------
module tb_uart_frame_tx;

  localparam int              CD   = 4;
  localparam int              DB   = 3;
  localparam int              HB   = 2;
  localparam logic [8*HB-1:0] HDRV = 16'h443D;
  localparam int              TEN  = 1;
  localparam int              PAR  = 1;
  localparam int              STB  = 2;
  localparam int              GAP  = 2;
  localparam int              MB   = HB + DB + ((TEN != 0) ? 2 : 0);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [8*DB-1:0] data_in;
  logic          ready, busy, done, tx;

  int vectors     = 0;
  int miscompares = 0;
  int msg_no      = 0;

  logic [31:0] exp_q[$];

  uart_frame_tx #(
    .CLK_DIV(CD), .DATA_BYTES(DB), .HDR_BYTES(HB), .HDR(HDRV),
    .TRAILER_EN(TEN), .PARITY(PAR), .STOP_BITS(STB), .GAP_BITS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready), .busy(busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {28'd0, tx, ready, busy, done};
  endfunction

  // Expected {tx,ready,busy,done} for each cycle after the accept edge.
  function automatic void build_expected(input logic [8*DB-1:0] d);
    logic [7:0]      bytes[$];
    logic [8*HB-1:0] hv;
    logic [7:0]      b;
    logic            bits[$];
    hv = HDRV;
    exp_q.delete();
    for (int h = 0; h < HB; h++) bytes.push_back(hv[8*(HB-1-h) +: 8]);
    for (int p = 0; p < DB; p++) bytes.push_back(d[8*(DB-1-p) +: 8]);
    if (TEN != 0) begin
      bytes.push_back(8'h0A);
      bytes.push_back(8'h0D);
    end
    exp_q.push_back(32'b1010);                          // first LOAD cycle
    for (int k = 0; k < bytes.size(); k++) begin
      b = bytes[k];
      bits.delete();
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
      if (PAR == 1) bits.push_back(1'($countones(b) % 2));
      if (PAR == 2) bits.push_back(1'(1 - $countones(b) % 2));
      for (int s = 0; s < STB; s++) bits.push_back(1'b1);
      foreach (bits[n])
        for (int c = 0; c < CD; c++) exp_q.push_back({28'd0, bits[n], 3'b010});
      if (k != bytes.size() - 1) begin
        for (int g = 0; g < GAP * CD; g++) exp_q.push_back(32'b1010);
        exp_q.push_back(32'b1010);                      // LOAD of next byte
      end
    end
    exp_q.push_back(32'b1101);                          // done cycle
  endfunction

  // Called at a negedge while the DUT is ready. hold keeps start high through
  // the done cycle so the caller's next message is accepted back-to-back;
  // disturb re-pulses start with new data in the middle of the message.
  task automatic run_msg(input logic [8*DB-1:0] d, input bit hold, input bit disturb);
    int n_exp;
    int done_cyc;
    build_expected(d);
    n_exp    = 1 + MB * (1 + (9 + ((PAR != 0) ? 1 : 0) + STB) * CD) + (MB - 1) * GAP * CD;
    done_cyc = 0;
    msg_no++;
    check($sformatf("m%0d.ready_before", msg_no), {31'd0, ready}, 32'd1);
    start   = 1'b1;
    data_in = d;
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("m%0d.c%0d", msg_no, i + 1), obs(), exp_q[i]);
      if (done && done_cyc == 0) done_cyc = i + 1;
      start = hold || (disturb && i == exp_q.size() / 2);
      if (disturb && i == exp_q.size() / 2) data_in = (8*DB)'($urandom);
    end
    check($sformatf("m%0d.len", msg_no), done_cyc, n_exp);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", obs(), 32'b1100);
    end
  endtask

  // Accept a message, let it run k cycles, then pulse reset mid-message.
  task automatic run_abort(input logic [8*DB-1:0] d, input int k);
    start   = 1'b1;
    data_in = d;
    @(posedge clk);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1 check("rst_async", obs(), 32'b1100);
    @(negedge clk);
    check("rst_hold", obs(), 32'b1100);
    rst = 1'b1;
    idle(20);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    data_in = '0;
    #12 check("reset", obs(), 32'b1100);
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    run_msg(24'h313233, 1'b0, 1'b0);
    idle(2);

    for (int m = 0; m < 3; m++) begin
      run_msg((8*DB)'($urandom), 1'b0, m == 1);
      idle($urandom_range(1, 4));
    end

    // start held high: three messages chained through their done cycles.
    run_msg((8*DB)'($urandom), 1'b1, 1'b0);
    run_msg((8*DB)'($urandom), 1'b1, 1'b0);
    run_msg((8*DB)'($urandom), 1'b0, 1'b0);
    idle(2);

    // Reset during a data bit of the first byte, then at a random point.
    run_abort((8*DB)'($urandom), 1 + CD + CD / 2);
    run_msg((8*DB)'($urandom), 1'b0, 1'b0);
    run_abort((8*DB)'($urandom), $urandom_range(2, 150));
    run_msg(24'hA7A75A, 1'b0, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
